// File: rtl/alioth_pipe_pkg.sv
// Shared types for the decode->execute elastic pipe.
package alioth_pipe_pkg;

  localparam int PIPE_OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  // Decode fields packed by the decoder; $bits of this sets DATA_W (160).
  typedef struct packed {
    logic [31:0] inst_addr;
    logic [4:0]  rs1_addr;
    logic        rs1_en;
    logic [4:0]  rs2_addr;
    logic        rs2_en;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [32:0] dec_info_bus;
    logic [31:0] imm;
    logic [31:0] old_pc;
  } idex_payload_t;

  // Entry count held in a given state.
  function automatic logic [PIPE_OCC_W-1:0] state_occ(pipe_state_e s);
    case (s)
      BUSY:    state_occ = 2'd1;
      FULL:    state_occ = 2'd2;
      default: state_occ = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating perf counter: synchronous clear, then add 0..3, clamp at all-ones.
module pipe_sat_cnt
  import alioth_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic [PIPE_OCC_W-1:0] inc_i,
  output logic [CNT_W-1:0]      cnt_o
);

  logic [CNT_W-1:0] base;
  logic [CNT_W:0]   sum;

  // Clear applies before the increment so clr+inc yields just the increment.
  always_comb begin
    base = clr_i ? '0 : cnt_o;
    sum  = {1'b0, base} + {{(CNT_W+1-PIPE_OCC_W){1'b0}}, inc_i};
  end

  // Carry out means overflow: clamp instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt_o <= '0;
    else if (sum[CNT_W])  cnt_o <= '1;
    else                  cnt_o <= sum[CNT_W-1:0];
  end

endmodule

// File: rtl/idu_ex_skid_pipe.sv
// Decode->execute elastic stage: main + skid entry, registered ready, flush.
module idu_ex_skid_pipe
  import alioth_pipe_pkg::*;
#(
  parameter int DATA_W        = 160,
  parameter bit ZERO_ON_FLUSH = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_W-1:0]     in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_W-1:0]     out_data_o,
  input  logic                  flush_i,
  output logic [PIPE_OCC_W-1:0] occ_o,
  output logic [CNT_W-1:0]      flush_cnt_o,
  input  logic                  flush_cnt_clr_i
);

  pipe_state_e         st_q, st_nxt;
  logic [DATA_W-1:0]   main_q, main_nxt;
  logic [DATA_W-1:0]   skid_q, skid_nxt;
  logic                accept, deliver;
  logic [PIPE_OCC_W-1:0] kill_cnt, cnt_inc;

  assign accept      = in_valid_i & in_ready_o;
  assign deliver     = out_valid_o & out_ready_i;
  assign out_valid_o = (st_q != EMPTY);
  assign out_data_o  = main_q;
  assign occ_o       = state_occ(st_q);

  // Entries that die on flush: held ones not delivered plus this cycle's beat.
  assign kill_cnt = occ_o - {1'b0, deliver} + {1'b0, accept};
  assign cnt_inc  = flush_i ? kill_cnt : '0;

  // Next state and entry contents; flush overrides all normal moves.
  always_comb begin
    st_nxt   = st_q;
    main_nxt = main_q;
    skid_nxt = skid_q;
    case (st_q)
      EMPTY: if (accept) begin
        st_nxt   = BUSY;
        main_nxt = in_data_i;
      end
      BUSY: begin
        if (accept && deliver) begin
          main_nxt = in_data_i;
        end else if (accept) begin
          st_nxt   = FULL;
          skid_nxt = in_data_i;
        end else if (deliver) begin
          st_nxt = EMPTY;
          if (ZERO_ON_FLUSH) main_nxt = '0;
        end
      end
      FULL: if (deliver) begin
        st_nxt   = BUSY;
        main_nxt = skid_q;
        if (ZERO_ON_FLUSH) skid_nxt = '0;
      end
      default: st_nxt = EMPTY;
    endcase
    if (flush_i) begin
      st_nxt = EMPTY;
      if (ZERO_ON_FLUSH) begin
        main_nxt = '0;
        skid_nxt = '0;
      end
    end
  end

  // State, payload registers and the registered upstream ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q       <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_o <= 1'b1;
    end else begin
      st_q       <= st_nxt;
      main_q     <= main_nxt;
      skid_q     <= skid_nxt;
      in_ready_o <= (st_nxt != FULL);
    end
  end

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (flush_cnt_clr_i),
    .inc_i (cnt_inc),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: doc/idu_ex_skid_pipe.md
Name: idu_ex_skid_pipe

Overview:
- Parametrised elastic successor to the decode→execute pipeline register.
- Replaces the global stall vector with a per-stage valid/ready handshake and a 2-entry skid buffer (main + skid):
  - full throughput with a registered upstream ready;
  - synchronous flush that kills every buffered entry;
  - saturating counter of flushed (killed) instructions for perf/debug.
- Sits between the decoder (payload = inst_addr, reg/csr addresses and enables, dec_info_bus, imm, old_pc, packed by the caller) and the execute/dispatch stage.

Parameters:
- DATA_W, 160, payload width in bits (≥1).
- ZERO_ON_FLUSH, 1, 1: killed or empty entries present an all-zero payload (a bubble); 0: the payload holds its last value, only valid drops.
- CNT_W, 16, width of the flushed-instruction counter (≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  stage can accept; registered (no in→out combinational path).
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  main entry valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  DATA_W  main entry payload; registered.
- flush_i  in  1  synchronous kill of all entries and of the input beat in the same cycle.
- occ_o  out  2  number of held entries, 0..2.
- flush_cnt_o  out  CNT_W  saturating count of valid entries killed by flush.
- flush_cnt_clr_i  in  1  synchronous clear of flush_cnt_o.

Behaviour:
- Reset (async assert, sync release), all registers:
  - state=EMPTY, in_ready_o=1, out_valid_o=0, out_data_o=0;
  - skid register=0, occ_o=0, flush_cnt_o=0.
- Handshakes:
  - accept = in_valid_i & in_ready_o;
  - deliver = out_valid_o & out_ready_i;
  - out_data_o is stable while out_valid_o=1 and out_ready_i=0;
  - in_data_i is sampled only on accept.
- Latency: 1 cycle from accept to out_valid_o when EMPTY. Sustained throughput is 1 beat/cycle.
- Ordering: FIFO, no reordering, no duplication.
- States: EMPTY (occ 0), BUSY (occ 1, main valid), FULL (occ 2, main+skid valid).
- Transitions without flush:
  - EMPTY: accept → BUSY, main←in.
  - BUSY:
    - accept & deliver → BUSY, main←in;
    - accept & !deliver → FULL, skid←in;
    - !accept & deliver → EMPTY;
    - otherwise hold.
  - FULL (in_ready_o=0, so no accept):
    - deliver → BUSY, main←skid;
    - otherwise hold.
- in_ready_o next value = (next state != FULL).
- Flush (priority over everything except reset):
  - next state=EMPTY, in_ready_o=1 next cycle;
  - the input beat of the flush cycle is dropped even if accepted;
  - a deliver in the flush cycle still completes (downstream sampled it);
  - if ZERO_ON_FLUSH=1, main and skid are cleared to 0.
- Flush counter:
  - on flush, add the number of valid entries killed = occ − deliver + accept;
  - saturate at 2^CNT_W−1, never wrap;
  - flush_cnt_clr_i in the same cycle as flush: clear wins, then the increment for that cycle is applied (result = killed count).
- ZERO_ON_FLUSH=1 also forces main←0 when leaving to EMPTY on a normal deliver.
- Reset mid-operation discards all entries; the counter is not incremented by reset.

Decomposition:
- Shared package (alioth_pipe_pkg):
  - typedef pipe_state_e {EMPTY, BUSY, FULL} (2 bits);
  - typedef idex_payload_t, a packed struct of the decode fields whose $bits sets DATA_W at instantiation;
  - constant PIPE_OCC_W=2.
- One sub-module, pipe_sat_cnt: saturating counter with CNT_W, clear and 0..3 increment, reused for other perf counters.
- The FSM and datapath stay in the top module.

Test Plan:
- Reset then idle: rst pulse mid-stream → all outputs 0, in_ready_o=1 within the reset cycle (async).
- Streaming: 8 beats 0x1..0x8 with out_ready_i=1 → out_data_o=0x1..0x8 on consecutive cycles, each 1 cycle after accept, occ_o=1 throughout.
- Backpressure:
  - beats A,B,C with out_ready_i=0 from the cycle after A → occ_o=2, in_ready_o=0, C held upstream;
  - release → A,B,C delivered in order, none lost or duplicated.
- Flush in FULL: occ 2, no deliver, in_valid_i=1 → next cycle occ_o=0, out_valid_o=0, out_data_o=0 (ZERO_ON_FLUSH=1), flush_cnt_o=2.
- Flush in BUSY with deliver and accept in the same cycle → delivered beat observed once, input dropped, flush_cnt_o += 1.
- Counter saturation: CNT_W=2, repeated FULL flushes → 2, 3, 3; flush with flush_cnt_clr_i from occ 2 → 2.
